// File: rtl/core_pkg.sv
// Shared core constants and types; holds the register-scoreboard defaults.
package core_pkg;

  localparam int unsigned NUM_REGS_RV32E = 16;
  localparam int unsigned NUM_REGS_RV32I = 32;

  localparam int unsigned SB_NUM_REGS     = NUM_REGS_RV32E;
  localparam int unsigned SB_NUM_SRC      = 2;
  localparam int unsigned SB_NUM_KILL     = 3;
  localparam int unsigned SB_MAX_INFLIGHT = 4;

  typedef logic [$clog2(SB_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/scoreboard_counter.sv
// Per-register in-flight write counter: one increment, summed decrements,
// clamps to zero on underflow and to MAX_INFLIGHT at the top.
module scoreboard_counter #(
  parameter int unsigned MAX_INFLIGHT = 4,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned DEC_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [DEC_W-1:0] dec_sum,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             underflow
);

  localparam int unsigned SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] w_up;
  logic [SUM_W-1:0] w_dec;
  logic [SUM_W-1:0] w_diff;
  logic             w_uflow;
  logic [CNT_W-1:0] w_next;

  always_comb begin
    w_up    = SUM_W'(r_cnt) + SUM_W'(inc);
    w_dec   = SUM_W'(dec_sum);
    w_diff  = w_up - w_dec;
    w_uflow = (w_dec > w_up);
    w_next  = CNT_W'(w_diff);
    if (w_uflow) begin
      w_next = '0;
    end else if (w_diff > SUM_W'(MAX_INFLIGHT)) begin
      w_next = CNT_W'(MAX_INFLIGHT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_next;
    end
  end

  assign cnt       = r_cnt;
  assign busy      = (r_cnt != '0);
  assign underflow = w_uflow;

endmodule

// File: rtl/register_scoreboard.sv
// Hazard tracker: counts in-flight writes per register and raises a
// combinational stall for unforwardable pending sources or a full counter.
module register_scoreboard
  import core_pkg::*;
#(
  parameter int unsigned NUM_REGS     = SB_NUM_REGS,
  parameter int unsigned NUM_SRC      = SB_NUM_SRC,
  parameter int unsigned NUM_KILL     = SB_NUM_KILL,
  parameter int unsigned MAX_INFLIGHT = SB_MAX_INFLIGHT
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  issue_valid,
  input  logic                                  issue_we,
  input  logic [$clog2(NUM_REGS)-1:0]           issue_rd,
  input  logic                                  wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0]           wb_rd,
  input  logic [NUM_KILL-1:0]                   kill_valid,
  input  logic [NUM_KILL*$clog2(NUM_REGS)-1:0]  kill_rd,
  input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]                    src_fwd_ok,
  output logic                                  stall,
  output logic [NUM_REGS-1:0]                   busy_mask,
  output logic                                  idle,
  output logic                                  underflow_err
);

  localparam int unsigned AW    = $clog2(NUM_REGS);
  localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned DEC_W = $clog2(NUM_KILL + 2);

  logic [CNT_W-1:0]    w_cnt     [NUM_REGS];
  logic [DEC_W-1:0]    w_dec_sum [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] w_inc;
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_uflow;
  logic                w_issue;
  logic                w_stall;
  logic                r_underflow_err;

  assign w_issue = issue_valid & issue_we & (issue_rd != '0);

  // Stall reduction over source ports plus the full-counter issue block.
  always_comb begin
    w_stall = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if ((src_addr[s*AW +: AW] != '0) && (w_cnt[src_addr[s*AW +: AW]] != '0) && !src_fwd_ok[s]) begin
        w_stall = 1'b1;
      end
    end
    if (w_issue && (w_cnt[issue_rd] == CNT_W'(MAX_INFLIGHT))) begin
      w_stall = 1'b1;
    end
  end

  // Address decode into per-register increment and summed decrements.
  always_comb begin
    w_inc = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      w_inc[r]     = w_issue & ~w_stall & (issue_rd == AW'(r));
      w_dec_sum[r] = DEC_W'(wb_valid && (wb_rd == AW'(r)));
      for (int unsigned k = 0; k < NUM_KILL; k++) begin
        w_dec_sum[r] = w_dec_sum[r] + DEC_W'(kill_valid[k] && (kill_rd[k*AW +: AW] == AW'(r)));
      end
    end
  end

  assign w_cnt[0]   = '0;
  assign w_busy[0]  = 1'b0;
  assign w_uflow[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    scoreboard_counter #(
      .MAX_INFLIGHT (MAX_INFLIGHT),
      .CNT_W        (CNT_W),
      .DEC_W        (DEC_W)
    ) u_counter (
      .clk       (clk),
      .rst       (rst),
      .inc       (w_inc[r]),
      .dec_sum   (w_dec_sum[r]),
      .cnt       (w_cnt[r]),
      .busy      (w_busy[r]),
      .underflow (w_uflow[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underflow_err <= 1'b0;
    end else if (|w_uflow) begin
      r_underflow_err <= 1'b1;
    end
  end

  assign stall         = w_stall;
  assign busy_mask     = w_busy;
  assign idle          = ~|w_busy;
  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_register_scoreboard.sv
// Randomized and directed bench for register_scoreboard against an
// integer-count reference model.
module tb_register_scoreboard;

  localparam int unsigned NR = 16;
  localparam int unsigned NS = 2;
  localparam int unsigned NK = 3;
  localparam int unsigned MI = 4;
  localparam int unsigned AW = 4;

  logic             clk;
  logic             rst;
  logic             issue_valid;
  logic             issue_we;
  logic [AW-1:0]    issue_rd;
  logic             wb_valid;
  logic [AW-1:0]    wb_rd;
  logic [NK-1:0]    kill_valid;
  logic [NK*AW-1:0] kill_rd;
  logic [NS*AW-1:0] src_addr;
  logic [NS-1:0]    src_fwd_ok;
  logic             stall;
  logic [NR-1:0]    busy_mask;
  logic             idle;
  logic             underflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt [NR];
  bit merr;

  register_scoreboard #(
    .NUM_REGS(NR), .NUM_SRC(NS), .NUM_KILL(NK), .MAX_INFLIGHT(MI)
  ) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd), .src_addr(src_addr),
    .src_fwd_ok(src_fwd_ok), .stall(stall), .busy_mask(busy_mask),
    .idle(idle), .underflow_err(underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_stall();
    for (int s = 0; s < int'(NS); s++) begin
      if (src_addr[s*AW +: AW] != 0 && mcnt[src_addr[s*AW +: AW]] != 0 && !src_fwd_ok[s]) return 1'b1;
    end
    if (issue_valid && issue_we && issue_rd != 0 && mcnt[issue_rd] == int'(MI)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NR-1:0] m_busy();
    logic [NR-1:0] b;
    b = '0;
    for (int r = 0; r < int'(NR); r++) b[r] = (mcnt[r] != 0);
    return b;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < int'(NR); r++) mcnt[r] = 0;
    merr = 1'b0;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_we = 1'b0; issue_rd = '0;
    wb_valid = 1'b0; wb_rd = '0;
    kill_valid = '0; kill_rd = '0;
    src_addr = '0; src_fwd_ok = '0;
  endtask

  // One clock: compare outputs mid-cycle, then advance the model across the edge.
  task automatic cycle();
    int nc [NR];
    bit st;
    int d;
    @(negedge clk);
    st = m_stall();
    check("stall", 32'(stall), 32'(st));
    check("busy_mask", 32'(busy_mask), 32'(m_busy()));
    check("idle", 32'(idle), 32'(m_busy() == '0));
    check("underflow_err", 32'(underflow_err), 32'(merr));
    nc[0] = 0;
    for (int r = 1; r < int'(NR); r++) begin
      d = (wb_valid && wb_rd == AW'(r)) ? 1 : 0;
      for (int k = 0; k < int'(NK); k++)
        if (kill_valid[k] && kill_rd[k*AW +: AW] == AW'(r)) d++;
      nc[r] = mcnt[r] + ((issue_valid && issue_we && !st && issue_rd == AW'(r)) ? 1 : 0) - d;
      if (nc[r] < 0) begin
        nc[r] = 0;
        merr  = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    for (int r = 0; r < int'(NR); r++) mcnt[r] = nc[r];
  endtask

  task automatic do_issue(input int rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = AW'(rd);
    cycle();
    issue_valid = 1'b0; issue_we = 1'b0;
  endtask

  task automatic do_wb(input int rd);
    wb_valid = 1'b1; wb_rd = AW'(rd);
    cycle();
    wb_valid = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b1;
    src_addr = NS*AW'($urandom);
    @(posedge clk);
    #1;
    check("rst_busy", 32'(busy_mask), 32'h0);
    check("rst_idle", 32'(idle), 32'h1);
    check("rst_uerr", 32'(underflow_err), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    rst = 1'b0;
    clear_inputs();

    // Simple RAW hazard, resolved by writeback.
    do_issue(5);
    src_addr[0 +: AW] = 4'd5;
    #1;
    check("raw_stall", 32'(stall), 32'h1);
    check("raw_busy5", 32'(busy_mask[5]), 32'h1);
    wb_valid = 1'b1; wb_rd = 4'd5;
    cycle();
    wb_valid = 1'b0;
    #1;
    check("raw_cleared", 32'(stall), 32'h0);
    check("raw_idle", 32'(idle), 32'h1);
    clear_inputs();

    // Forwarding covers the hazard; x0 never tracked.
    do_issue(5);
    src_addr[0 +: AW] = 4'd5; src_fwd_ok = 2'b01;
    #1;
    check("fwd_nostall", 32'(stall), 32'h0);
    do_wb(5);
    clear_inputs();
    do_issue(0);
    src_addr = {4'd0, 4'd0};
    #1;
    check("x0_stall", 32'(stall), 32'h0);
    check("x0_busy", 32'(busy_mask), 32'h0);
    cycle();

    // Saturation at MAX_INFLIGHT.
    for (int i = 0; i < int'(MI); i++) do_issue(3);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd3;
    #1;
    check("sat_stall", 32'(stall), 32'h1);
    cycle();
    wb_valid = 1'b1; wb_rd = 4'd3;
    cycle();
    wb_valid = 1'b0;
    #1;
    check("sat_resume", 32'(stall), 32'h0);
    cycle();
    #1;
    check("sat_refull", 32'(stall), 32'h1);
    clear_inputs();
    for (int i = 0; i < int'(MI); i++) begin
      do_wb(3);
      check("sat_drain", 32'(busy_mask[3]), 32'((i < int'(MI) - 1) ? 1 : 0));
    end

    // Simultaneous issue/retire on x7, double kill underflowing x9.
    do_issue(7); do_issue(7); do_issue(9);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = 4'd7;
    wb_valid = 1'b1; wb_rd = 4'd7;
    kill_valid = 3'b011; kill_rd = {4'd0, 4'd9, 4'd9};
    cycle();
    clear_inputs();
    #1;
    check("sim_busy7", 32'(busy_mask[7]), 32'h1);
    check("sim_busy9", 32'(busy_mask[9]), 32'h0);
    check("sim_uerr", 32'(underflow_err), 32'h1);
    do_wb(7);
    check("sim_still7", 32'(busy_mask[7]), 32'h1);
    do_wb(7);
    check("sim_idle", 32'(idle), 32'h1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) do_issue(6);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy_mask), 32'h0);
    check("arst_idle", 32'(idle), 32'h1);
    check("arst_uerr", 32'(underflow_err), 32'h0);
    model_reset();
    #1;
    rst = 1'b0;

    // Branch flush kills three writers at once.
    do_issue(1); do_issue(2); do_issue(4);
    kill_valid = 3'b111; kill_rd = {4'd4, 4'd2, 4'd1};
    cycle();
    clear_inputs();
    #1;
    check("flush_idle", 32'(idle), 32'h1);
    check("flush_uerr", 32'(underflow_err), 32'h0);

    // Randomized traffic on a small register window for dense hazards.
    for (int i = 0; i < 1500; i++) begin
      if (i % 300 == 299) begin
        rst = 1'b1;
        #1;
        model_reset();
        rst = 1'b0;
        #1;
      end
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_we    = ($urandom_range(0, 9) < 8);
      issue_rd    = AW'($urandom_range(0, 7));
      wb_valid    = ($urandom_range(0, 9) < 4);
      wb_rd       = AW'($urandom_range(0, 7));
      for (int k = 0; k < int'(NK); k++) begin
        kill_valid[k]       = ($urandom_range(0, 9) == 0);
        kill_rd[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      for (int s = 0; s < int'(NS); s++) begin
        src_addr[s*AW +: AW] = AW'($urandom_range(0, 7));
        src_fwd_ok[s]        = ($urandom_range(0, 2) == 0);
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_scoreboard.md
# register_scoreboard

Parametrised hazard tracker for the in-order core pipeline. It keeps a per-register count of in-flight writes and raises a combinational stall when a source operand is pending and cannot be forwarded. It generalises the fixed four-stage equality compare in the ID stage to any register count, read-port count and squash width. It sits beside the ID stage, is fed by the issue, writeback and branch-flush paths, and drives the global stall.

## Interface
- NUM_REGS, 16: architectural registers (16 for RV32E, 32 for RV32I); index 0 is hardwired zero.
- NUM_SRC, 2: source-operand query ports.
- NUM_KILL, 3: squash ports, one per flushable pipeline register.
- MAX_INFLIGHT, 4: maximum outstanding writes per register; CNT_W = $clog2(MAX_INFLIGHT+1).
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous and active-high. Clears all state.
- issue_valid  in  1  an instruction leaves ID this cycle.
- issue_we  in  1  that instruction writes a register.
- issue_rd  in  $clog2(NUM_REGS)  destination of the issuing instruction.
- wb_valid  in  1  a register write commits this cycle.
- wb_rd  in  $clog2(NUM_REGS)  committed destination.
- kill_valid  in  NUM_KILL  per-port squash of an in-flight writer.
- kill_rd  in  NUM_KILL × $clog2(NUM_REGS)  destination of each squashed writer.
- src_addr  in  NUM_SRC × $clog2(NUM_REGS)  source registers of the instruction in ID.
- src_fwd_ok  in  NUM_SRC  the forwarding unit can supply this source this cycle.
- stall  out  1  combinational hold of IF/ID.
- busy_mask  out  NUM_REGS  bit r set when cnt[r] != 0.
- idle  out  1  all counts zero.
- underflow_err  out  1  sticky error flag, cleared only by rst.

## Operation
- State: cnt[r], CNT_W bits, for r in 1..NUM_REGS-1. cnt[0] is constant 0.
- Increment: +1 to cnt[issue_rd] when issue_valid & issue_we & ~stall & issue_rd != 0. issue_valid while stall=1 has no effect.
- Decrement: each of wb_valid and kill_valid[k] applies −1 to its register. Several ports may target the same register in one cycle; their decrements are summed. Ports targeting r=0 are ignored.
- Net update per register: cnt_next = cnt + inc − dec_sum. Issue and retire of the same register in one cycle leave the count unchanged.
- Underflow: when dec_sum > cnt + inc, cnt_next = 0 and underflow_err is set on that edge.
- stall = OR over s of (src_addr[s] != 0 & cnt[src_addr[s]] != 0 & ~src_fwd_ok[s]) OR (issue_valid & issue_we & issue_rd != 0 & cnt[issue_rd] == MAX_INFLIGHT).
- Because the full count prevents an increment, a count never exceeds MAX_INFLIGHT.
- idle = ~|busy_mask.

## Timing
- Reset values: all cnt = 0, busy_mask = 0, idle = 1, underflow_err = 0, stall = 0 given any inputs with src_fwd_ok ignored.
- Asserting rst mid-operation discards all pending counts immediately, without waiting for a clock edge.
- Counts update on the rising clk edge. Issue at edge N is visible in busy_mask and stall from cycle N+1.
- Writeback or kill at edge N clears the dependency from cycle N+1. In the same cycle the dependency must be covered by src_fwd_ok.
- stall, busy_mask and idle are combinational from the registered counts and the current inputs. There is no internal bypass of in-cycle updates.
- A branch flush drives up to NUM_KILL kills in one cycle. Each kill decrements the count, so no extra flush state is needed.

## Structure
- The shared package core_pkg holds:
  - NUM_REGS_RV32E = 16 and NUM_REGS_RV32I = 32;
  - the reg_addr_t typedef (logic [$clog2(NUM_REGS)-1:0]);
  - the scoreboard default constants.
- One sub-module, scoreboard_counter, is instantiated once per register via generate.
  - Inputs: inc, dec_sum.
  - Outputs: cnt, busy, underflow.
  - Behaviour: saturating up/down counter with async reset.
- The top level owns address decoding, the per-register dec_sum adders, the stall reduction and the sticky error flop.

## Test plan
- **Simple RAW hazard.** Issue x5 (issue_we=1); next cycle src_addr[0]=5 with src_fwd_ok=0 → stall=1 and busy_mask[5]=1. Assert wb_valid with wb_rd=5 → from the next cycle stall=0 and idle=1.
- **Forwarding and x0.** Same as above with src_fwd_ok[0]=1 → stall=0. Issue to x0, then query x0 → busy_mask=0 and stall never asserts.
- **Saturation.** MAX_INFLIGHT=4: issue x3 four times → cnt=4. A fifth issue of x3 → stall=1 and the count stays 4. Retire once → cnt=3 and the stalled issue then increments it back to 4.
- **Simultaneous events.** With cnt[7]=2 and cnt[9]=1, in one cycle: issue x7, wb x7, kill x9, kill x9 → cnt[7]=2, cnt[9]=0, underflow_err=1.
- **Branch flush.** Issue to x1, x2 and x4 on consecutive cycles. In the next cycle, kill all three via kill ports 0–2 → idle=1 and no error.
- **Async reset.** Set cnt[6]=3, then pulse rst between clock edges → busy_mask=0 and idle=1 before the next edge. underflow_err clears.
